// File: rtl/node_pkg.sv
// Shared constants and types for the node endpoint: default widths, FIFO depth and FSM states.
package node_pkg;

    localparam int unsigned NODE_PKT_W      = 32;
    localparam int unsigned NODE_FLIT_W     = 8;
    localparam int unsigned NODE_FIFO_DEPTH = 4;

    typedef logic [NODE_PKT_W-1:0] pkt_t;

    typedef enum logic {TxIdle, TxSend} tx_state_e;
    typedef enum logic {RxIdle, RxRecv} rx_state_e;

endpackage

// File: rtl/node_sync_fifo.sv
// Synchronous FIFO with pointers wrapping modulo DEPTH; a write while full succeeds only with a
// simultaneous read.
module node_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_re, do_we;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    // Gated so the head reads as zero while empty, independent of stale storage.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];

    assign do_re = re && !empty;
    assign do_we = we && (!full || do_re);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_we) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_re) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_we, do_re})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_we) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/node_endpoint_serdes.sv
// Node endpoint: outbound FIFO + flit serialiser towards the router, flit deserialiser + inbound
// FIFO towards the testbench. Flits travel MSB first in both directions.
module node_endpoint_serdes
    import node_pkg::*;
#(
    parameter int unsigned PKT_W  = NODE_PKT_W,
    parameter int unsigned FLIT_W = NODE_FLIT_W,
    parameter int unsigned DEPTH  = NODE_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic              ovf,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    input  logic              pkt_out_ready,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [FLIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [FLIT_W-1:0] payload_inbound
);

    localparam int unsigned N    = PKT_W / FLIT_W;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    // Outbound path
    logic [PKT_W-1:0] out_head;
    logic             out_full, out_empty, tx_pop;
    logic             ovf_q, ovf_d;

    tx_state_e        tx_state_q, tx_state_d;
    logic [PKT_W-1:0] tx_sr_q, tx_sr_d;
    logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;

    assign tx_pop = (tx_state_q == TxIdle) && !out_empty && free_outbound;

    node_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .we       (pkt_in_avail),
        .re       (tx_pop),
        .data_in  (pkt_in),
        .data_out (out_head),
        .full     (out_full),
        .empty    (out_empty)
    );

    // A write that coincides with a pop from a full FIFO is accepted, so it is not an overflow.
    assign ovf_d   = ovf_q | (pkt_in_avail && out_full && !tx_pop);
    assign cQ_full = out_full;
    assign ovf     = ovf_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TxIdle: begin
                if (tx_pop) begin
                    tx_state_d = TxSend;
                    tx_sr_d    = out_head;
                    tx_cnt_d   = '0;
                end
            end
            TxSend: begin
                if (tx_cnt_q == LastCnt) begin
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    tx_sr_d  = tx_sr_q << FLIT_W;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign put_outbound     = (tx_state_q == TxSend);
    assign payload_outbound = put_outbound ? tx_sr_q[PKT_W-1 -: FLIT_W] : '0;

    // Inbound path
    logic [PKT_W-1:0] in_head, rx_asm;
    logic             in_full, in_empty, in_push, rx_flit_ok;

    rx_state_e        rx_state_q, rx_state_d;
    logic [PKT_W-1:0] rx_sr_q, rx_sr_d;
    logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;

    assign free_inbound = (rx_state_q == RxIdle) && !in_full;
    // In RECV free_inbound is low but flits are still expected; in IDLE a busy endpoint ignores them.
    assign rx_flit_ok   = put_inbound && ((rx_state_q == RxRecv) || free_inbound);
    assign rx_asm       = (((rx_state_q == RxIdle) ? '0 : rx_sr_q) << FLIT_W)
                        | PKT_W'(payload_inbound);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        in_push    = 1'b0;
        if (rx_flit_ok) begin
            rx_sr_d = rx_asm;
            if (rx_cnt_q == LastCnt) begin
                in_push    = 1'b1;
                rx_state_d = RxIdle;
                rx_cnt_d   = '0;
            end else begin
                rx_state_d = RxRecv;
                rx_cnt_d   = rx_cnt_q + 1'b1;
            end
        end
    end

    node_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .we       (in_push),
        .re       (pkt_out_ready),
        .data_in  (rx_asm),
        .data_out (in_head),
        .full     (in_full),
        .empty    (in_empty)
    );

    assign pkt_out       = in_head;
    assign pkt_out_avail = !in_empty;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_q      <= 1'b0;
            tx_state_q <= TxIdle;
            tx_sr_q    <= '0;
            tx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            rx_sr_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            ovf_q      <= ovf_d;
            tx_state_q <= tx_state_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

endmodule
